rob_multi_commit: RTL and testbench

Parametrised reorder buffer, next generation of the core's single-commit ROB. Accepts one dispatched instruction per cycle. Takes results from WB_CH writeback channels and commits up to COMMIT_W ready entries per cycle, in order. Provides operand forwarding to the dispatcher, head-of-queue release to the LSB, predictor update and mispredict flush.

---
 rtl/rob_multi_commit_if.sv | 61 ++++++
 rtl/rob_multi_commit.sv | 190 +++++++++++++++++++
 tb/tb_rob_multi_commit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_multi_commit_if.sv
// Bundle of dispatch, operand lookup, writeback, commit and redirect signals
// between the core and the reorder buffer.
interface rob_multi_commit_if #(
  parameter int ID_W     = 4,
  parameter int WB_CH    = 2,
  parameter int COMMIT_W = 2
);
  logic                     disp_valid;
  logic [31:0]              disp_pc;
  logic [4:0]               disp_rd;
  logic                     disp_is_br;
  logic                     disp_is_ls;
  logic                     disp_pred_taken;
  logic                     rob_full;
  logic [ID_W-1:0]          alloc_id;

  logic [ID_W-1:0]          q1_id;
  logic [ID_W-1:0]          q2_id;
  logic                     q1_ready;
  logic                     q2_ready;
  logic [31:0]              q1_val;
  logic [31:0]              q2_val;

  logic [WB_CH-1:0]         wb_valid;
  logic [WB_CH*ID_W-1:0]    wb_id;
  logic [WB_CH*32-1:0]      wb_res;
  logic [WB_CH-1:0]         wb_taken;
  logic [WB_CH*32-1:0]      wb_target;

  logic                     ls_commit;
  logic [ID_W-1:0]          ls_id;

  logic [COMMIT_W-1:0]      commit_valid;
  logic [COMMIT_W*5-1:0]    commit_rd;
  logic [COMMIT_W*32-1:0]   commit_res;
  logic [COMMIT_W*ID_W-1:0] commit_id;

  logic                     pred_en;
  logic [31:0]              pred_pc;
  logic                     pred_taken;
  logic                     flush;
  logic [31:0]              true_pc;

  modport master (
    output disp_valid, disp_pc, disp_rd, disp_is_br, disp_is_ls, disp_pred_taken,
    output q1_id, q2_id,
    output wb_valid, wb_id, wb_res, wb_taken, wb_target,
    input  rob_full, alloc_id, q1_ready, q2_ready, q1_val, q2_val,
    input  ls_commit, ls_id, commit_valid, commit_rd, commit_res, commit_id,
    input  pred_en, pred_pc, pred_taken, flush, true_pc
  );

  modport slave (
    input  disp_valid, disp_pc, disp_rd, disp_is_br, disp_is_ls, disp_pred_taken,
    input  q1_id, q2_id,
    input  wb_valid, wb_id, wb_res, wb_taken, wb_target,
    output rob_full, alloc_id, q1_ready, q2_ready, q1_val, q2_val,
    output ls_commit, ls_id, commit_valid, commit_rd, commit_res, commit_id,
    output pred_en, pred_pc, pred_taken, flush, true_pc
  );
endinterface

// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-channel writeback and up to COMMIT_W in-order
// commits per cycle; a mispredicted branch commit flushes the whole buffer.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int ID_W     = 4,
  parameter int WB_CH    = 2,
  parameter int COMMIT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  rob_multi_commit_if.slave bus
);
  localparam int CNT_W = ID_W + 1;

  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  tail;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_ready;
  logic [DEPTH-1:0] e_is_br;
  logic [DEPTH-1:0] e_is_ls;
  logic [DEPTH-1:0] e_pred;
  logic [DEPTH-1:0] e_taken;
  logic [31:0]      e_pc     [DEPTH];
  logic [31:0]      e_res    [DEPTH];
  logic [31:0]      e_target [DEPTH];
  logic [4:0]       e_rd     [DEPTH];

  logic                rob_full;
  logic                disp_fire;
  logic [WB_CH-1:0]    wb_hit;
  logic                q1_ready;
  logic                q2_ready;
  logic [31:0]         q1_val;
  logic [31:0]         q2_val;

  logic [COMMIT_W-1:0] c_go;
  logic [ID_W-1:0]     c_idx [COMMIT_W];
  logic [CNT_W-1:0]    n_commit;
  logic                chain;
  logic                br_hit;
  logic [ID_W-1:0]     br_idx;
  logic                br_mis;

  logic [COMMIT_W-1:0]      commit_valid_q;
  logic [COMMIT_W*5-1:0]    commit_rd_q;
  logic [COMMIT_W*32-1:0]   commit_res_q;
  logic [COMMIT_W*ID_W-1:0] commit_id_q;
  logic                     pred_en_q;
  logic [31:0]              pred_pc_q;
  logic                     pred_taken_q;
  logic                     flush_q;
  logic [31:0]              true_pc_q;

  // Full/empty come from count alone; head==tail is ambiguous with all slots usable.
  assign rob_full  = (count == CNT_W'(DEPTH));
  assign disp_fire = bus.disp_valid && !rob_full;

  assign bus.rob_full  = rob_full;
  assign bus.alloc_id  = tail;
  assign bus.ls_commit = (count != '0) && e_valid[head] && e_is_ls[head];
  assign bus.ls_id     = head;

  always_comb begin
    wb_hit = '0;
    for (int k = 0; k < WB_CH; k++) begin
      wb_hit[k] = rdy && bus.wb_valid[k] && e_valid[bus.wb_id[k*ID_W +: ID_W]];
    end
  end

  // Descending scan so the lowest channel overrides on a shared tag.
  always_comb begin
    q1_ready = e_ready[bus.q1_id];
    q1_val   = e_res[bus.q1_id];
    q2_ready = e_ready[bus.q2_id];
    q2_val   = e_res[bus.q2_id];
    for (int k = WB_CH - 1; k >= 0; k--) begin
      if (wb_hit[k] && (bus.wb_id[k*ID_W +: ID_W] == bus.q1_id)) begin
        q1_ready = 1'b1;
        q1_val   = bus.wb_res[k*32 +: 32];
      end
      if (wb_hit[k] && (bus.wb_id[k*ID_W +: ID_W] == bus.q2_id)) begin
        q2_ready = 1'b1;
        q2_val   = bus.wb_res[k*32 +: 32];
      end
    end
  end

  assign bus.q1_ready = q1_ready;
  assign bus.q1_val   = q1_val;
  assign bus.q2_ready = q2_ready;
  assign bus.q2_val   = q2_val;

  // Loads/stores only retire from slot 0, and nothing follows a branch in the same cycle.
  always_comb begin
    c_go     = '0;
    n_commit = '0;
    chain    = 1'b1;
    br_hit   = 1'b0;
    br_idx   = '0;
    for (int s = 0; s < COMMIT_W; s++) begin
      c_idx[s] = head + ID_W'(s);
      if (chain && e_valid[c_idx[s]] && e_ready[c_idx[s]] &&
          ((s == 0) || (!e_is_ls[c_idx[s]] && !br_hit))) begin
        c_go[s]  = 1'b1;
        n_commit = n_commit + CNT_W'(1);
        if (e_is_br[c_idx[s]]) begin
          br_hit = 1'b1;
          br_idx = c_idx[s];
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  assign br_mis = br_hit && (e_taken[br_idx] != e_pred[br_idx]);

  always_ff @(posedge clk) begin
    if (rst || flush_q) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      e_valid        <= '0;
      e_ready        <= '0;
      commit_valid_q <= '0;
      commit_rd_q    <= '0;
      commit_res_q   <= '0;
      commit_id_q    <= '0;
      pred_en_q      <= 1'b0;
      pred_pc_q      <= '0;
      pred_taken_q   <= 1'b0;
      flush_q        <= 1'b0;
      true_pc_q      <= '0;
    end else if (rdy) begin
      for (int k = WB_CH - 1; k >= 0; k--) begin
        if (wb_hit[k]) begin
          e_ready[bus.wb_id[k*ID_W +: ID_W]]  <= 1'b1;
          e_res[bus.wb_id[k*ID_W +: ID_W]]    <= bus.wb_res[k*32 +: 32];
          e_taken[bus.wb_id[k*ID_W +: ID_W]]  <= bus.wb_taken[k];
          e_target[bus.wb_id[k*ID_W +: ID_W]] <= bus.wb_target[k*32 +: 32];
        end
      end

      for (int s = 0; s < COMMIT_W; s++) begin
        commit_valid_q[s]             <= c_go[s];
        commit_rd_q[s*5 +: 5]         <= c_go[s] ? e_rd[c_idx[s]] : 5'd0;
        commit_res_q[s*32 +: 32]      <= c_go[s] ? e_res[c_idx[s]] : 32'd0;
        commit_id_q[s*ID_W +: ID_W]   <= c_go[s] ? c_idx[s] : '0;
        if (c_go[s]) begin
          e_valid[c_idx[s]] <= 1'b0;
        end
      end

      pred_en_q    <= br_hit;
      pred_pc_q    <= br_hit ? e_pc[br_idx] : 32'd0;
      pred_taken_q <= br_hit && e_taken[br_idx];
      flush_q      <= br_mis;
      true_pc_q    <= br_mis ? (e_taken[br_idx] ? e_target[br_idx] : e_pc[br_idx] + 32'd4)
                             : 32'd0;

      if (disp_fire) begin
        e_valid[tail]  <= 1'b1;
        e_ready[tail]  <= 1'b0;
        e_pc[tail]     <= bus.disp_pc;
        e_rd[tail]     <= bus.disp_rd;
        e_is_br[tail]  <= bus.disp_is_br;
        e_is_ls[tail]  <= bus.disp_is_ls;
        e_pred[tail]   <= bus.disp_pred_taken;
        tail           <= tail + ID_W'(1);
      end

      head  <= head + n_commit[ID_W-1:0];
      count <= count + CNT_W'(disp_fire) - n_commit;
    end
  end

  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_res   = commit_res_q;
  assign bus.commit_id    = commit_id_q;
  assign bus.pred_en      = pred_en_q;
  assign bus.pred_pc      = pred_pc_q;
  assign bus.pred_taken   = pred_taken_q;
  assign bus.flush        = flush_q;
  assign bus.true_pc      = true_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: a queue-based program-order model predicts each
// cycle's commit group; a monitor compares what the ROB retires against it.
module tb_rob_multi_commit;
  localparam int DEPTH = 16;
  localparam int ID_W  = 4;
  localparam int WB_CH = 2;
  localparam int CW    = 2;

  logic clk, rst, rdy;
  rob_multi_commit_if #(.ID_W(ID_W), .WB_CH(WB_CH), .COMMIT_W(CW)) bus ();

  rob_multi_commit #(.DEPTH(DEPTH), .ID_W(ID_W), .WB_CH(WB_CH), .COMMIT_W(CW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          is_br, is_ls, pred, rdy_b, taken;
    logic [31:0] res, target;
  } ent_t;

  typedef struct packed {
    int          cyc;
    logic [1:0]  cv;
    logic [9:0]  crd;
    logic [63:0] cres;
    logic [7:0]  cid;
    bit          pe;
    logic [31:0] ppc;
    bit          pt;
    bit          fl;
    logic [31:0] tpc;
  } out_t;

  ent_t mq[$];
  out_t exp_q[$];
  out_t last_out;
  bit   last_nz;
  int   mtail;
  bit   flush_pend;

  int n_cmp, n_err, cyc;

  // stimulus for the upcoming edge
  bit          s_rst, s_rdy, s_disp, s_is_br, s_is_ls, s_pred;
  logic [31:0] s_pc;
  logic [4:0]  s_rd;
  logic [3:0]  s_q1, s_q2;
  logic [1:0]  s_wbv, s_wbtaken;
  logic [3:0]  s_wbid     [2];
  logic [31:0] s_wbres    [2];
  logic [31:0] s_wbtarget [2];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int find(input logic [3:0] tag);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic clr_stim();
    s_rst = 0; s_rdy = 1; s_disp = 0; s_is_br = 0; s_is_ls = 0; s_pred = 0;
    s_pc = '0; s_rd = '0; s_q1 = '0; s_q2 = '0; s_wbv = '0; s_wbtaken = '0;
    for (int k = 0; k < 2; k++) begin
      s_wbid[k] = '0; s_wbres[k] = '0; s_wbtarget[k] = '0;
    end
  endtask

  task automatic lookup_exp(input logic [3:0] id, output bit f, output bit r, output logic [31:0] v);
    int idx;
    idx = find(id);
    f = (idx >= 0);
    r = 0;
    v = '0;
    if (f) begin
      r = mq[idx].rdy_b;
      v = mq[idx].res;
      if (s_rdy)
        for (int k = 1; k >= 0; k--)
          if (s_wbv[k] && s_wbid[k] == id) begin
            r = 1;
            v = s_wbres[k];
          end
    end
  endtask

  task automatic drive_check();
    bit f, r;
    logic [31:0] v;
    @(negedge clk);
    rst = s_rst;
    rdy = s_rdy;
    bus.disp_valid = s_disp; bus.disp_pc = s_pc; bus.disp_rd = s_rd;
    bus.disp_is_br = s_is_br; bus.disp_is_ls = s_is_ls; bus.disp_pred_taken = s_pred;
    bus.q1_id = s_q1; bus.q2_id = s_q2;
    bus.wb_valid = s_wbv; bus.wb_taken = s_wbtaken;
    bus.wb_id = {s_wbid[1], s_wbid[0]};
    bus.wb_res = {s_wbres[1], s_wbres[0]};
    bus.wb_target = {s_wbtarget[1], s_wbtarget[0]};
    #1;
    if (!s_rst) begin
      chk("rob_full", bus.rob_full, 64'(mq.size() == DEPTH));
      chk("alloc_id", bus.alloc_id, 64'(mtail));
      if (mq.size() > 0) begin
        chk("ls_commit", bus.ls_commit, 64'(mq[0].is_ls));
        chk("ls_id", bus.ls_id, 64'(mq[0].tag));
      end else begin
        chk("ls_commit_empty", bus.ls_commit, 0);
        chk("ls_id_empty", bus.ls_id, 64'(mtail));
      end
      if (!flush_pend) begin
        lookup_exp(s_q1, f, r, v);
        if (f) begin
          chk("q1_ready", bus.q1_ready, 64'(r));
          if (r) chk("q1_val", bus.q1_val, 64'(v));
        end
        lookup_exp(s_q2, f, r, v);
        if (f) begin
          chk("q2_ready", bus.q2_ready, 64'(r));
          if (r) chk("q2_val", bus.q2_val, 64'(v));
        end
      end
    end
  endtask

  // Advance the program-order model across the coming clock edge.
  task automatic model_step();
    out_t o;
    bit full, br, nz;
    int n, idx;
    ent_t e;
    o = '0;
    o.cyc = cyc + 1;
    if (s_rst || flush_pend) begin
      mq.delete();
      mtail = 0;
      flush_pend = 0;
      last_nz = 0;
      return;
    end
    if (!s_rdy) begin
      if (last_nz) begin
        o = last_out;
        o.cyc = cyc + 1;
        exp_q.push_back(o);
      end
      return;
    end
    full = (mq.size() == DEPTH);
    n = 0;
    br = 0;
    for (int s = 0; s < CW; s++) begin
      if (s >= mq.size()) break;
      if (!mq[s].rdy_b) break;
      if (s > 0 && (mq[s].is_ls || br)) break;
      o.cv[s] = 1'b1;
      o.crd[s*5 +: 5] = mq[s].rd;
      o.cres[s*32 +: 32] = mq[s].res;
      o.cid[s*4 +: 4] = mq[s].tag;
      n++;
      if (mq[s].is_br) begin
        br = 1;
        o.pe = 1;
        o.ppc = mq[s].pc;
        o.pt = mq[s].taken;
        if (mq[s].taken != mq[s].pred) begin
          o.fl = 1;
          o.tpc = mq[s].taken ? mq[s].target : mq[s].pc + 32'd4;
        end
      end
    end
    for (int k = 1; k >= 0; k--) begin
      if (s_wbv[k]) begin
        idx = find(s_wbid[k]);
        if (idx >= 0) begin
          mq[idx].rdy_b = 1;
          mq[idx].res = s_wbres[k];
          mq[idx].taken = s_wbtaken[k];
          mq[idx].target = s_wbtarget[k];
        end
      end
    end
    for (int i = 0; i < n; i++) void'(mq.pop_front());
    if (s_disp && !full) begin
      e = '0;
      e.tag = 4'(mtail); e.pc = s_pc; e.rd = s_rd;
      e.is_br = s_is_br; e.is_ls = s_is_ls; e.pred = s_pred;
      mq.push_back(e);
      mtail = (mtail + 1) % DEPTH;
    end
    if (o.fl) flush_pend = 1;
    nz = (o.cv != 0) || o.pe || o.fl;
    if (nz) exp_q.push_back(o);
    last_out = o;
    last_nz = nz;
  endtask

  task automatic step();
    drive_check();
    model_step();
    clr_stim();
  endtask

  task automatic reset_dut();
    clr_stim(); s_rst = 1; step();
    s_rst = 1; step();
  endtask

  task automatic set_disp(input logic [31:0] pc, input logic [4:0] rd,
                          input bit br, input bit ls, input bit pred);
    s_disp = 1; s_pc = pc; s_rd = rd; s_is_br = br; s_is_ls = ls; s_pred = pred;
  endtask

  task automatic set_wb(input int k, input logic [3:0] id, input logic [31:0] res,
                        input bit taken, input logic [31:0] tgt);
    s_wbv[k] = 1'b1; s_wbid[k] = id; s_wbres[k] = res; s_wbtaken[k] = taken; s_wbtarget[k] = tgt;
  endtask

  task automatic scen_inorder(input bit stall);
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      set_disp(32'(i * 4), 5'(i + 1), 0, 0, 0);
      step();
    end
    set_wb(0, 4'd2, 32'h0000_0222, 0, '0); step();
    set_wb(0, 4'd0, 32'h0000_0100, 0, '0); set_wb(1, 4'd1, 32'h0000_0111, 0, '0); step();
    step();
    if (stall)
      for (int i = 0; i < 3; i++) begin
        s_rdy = 0;
        set_disp(32'h40, 5'd9, 0, 0, 0);
        set_wb(0, 4'd2, 32'hBAD0_0000, 0, '0);
        step();
      end
    repeat (3) step();
  endtask

  task automatic rand_cycle(input bit allow_disp);
    int cands[$];
    int r, idx;
    logic [3:0] tag;
    s_rdy = ($urandom_range(9) != 0);
    if (allow_disp && $urandom_range(9) < 7) begin
      r = $urandom_range(19);
      set_disp({$urandom_range(32'h3FFF_FFFF), 2'b00}, 5'($urandom_range(31)),
               (r >= 5 && r < 8), (r < 5), 1'($urandom_range(1)));
    end
    foreach (mq[i]) if (!mq[i].rdy_b) cands.push_back(int'(mq[i].tag));
    for (int k = 0; k < 2; k++) begin
      if ($urandom_range(1) == 0) continue;
      if (cands.size() > 0 && $urandom_range(9) != 0) tag = 4'(cands[$urandom_range(cands.size() - 1)]);
      else if (mq.size() < DEPTH) tag = 4'(mtail);
      else continue;
      idx = find(tag);
      set_wb(k, tag, $urandom, 1'($urandom_range(1)), $urandom);
      if (idx >= 0 && mq[idx].is_br)
        s_wbtaken[k] = ($urandom_range(5) == 0) ? !mq[idx].pred : mq[idx].pred;
    end
    if (mq.size() > 0) begin
      s_q1 = mq[$urandom_range(mq.size() - 1)].tag;
      s_q2 = mq[$urandom_range(mq.size() - 1)].tag;
    end
  endtask

  initial begin
    out_t o;
    forever begin
      @(posedge clk);
      #1;
      if (bus.commit_valid != 0 || bus.pred_en || bus.flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_commit: got valid=%0h pred_en=%0b flush=%0b expected nothing (cycle %0d)",
                   bus.commit_valid, bus.pred_en, bus.flush, cyc);
        end else begin
          o = exp_q.pop_front();
          chk("commit_cycle", 64'(cyc), 64'(o.cyc));
          chk("commit_valid", bus.commit_valid, o.cv);
          chk("commit_rd", bus.commit_rd, o.crd);
          chk("commit_res", bus.commit_res, o.cres);
          chk("commit_id", bus.commit_id, o.cid);
          chk("pred_en", bus.pred_en, o.pe);
          chk("pred_pc", bus.pred_pc, o.ppc);
          chk("pred_taken", bus.pred_taken, o.pt);
          chk("flush", bus.flush, o.fl);
          chk("true_pc", bus.true_pc, o.tpc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        o = exp_q.pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_commit: got no output expected valid=%0h pred_en=%0b flush=%0b (cycle %0d)",
                 o.cv, o.pe, o.fl, cyc);
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; mtail = 0; flush_pend = 0; last_nz = 0; last_out = '0;
    rst = 1; rdy = 1;
    bus.disp_valid = 0; bus.disp_pc = '0; bus.disp_rd = '0; bus.disp_is_br = 0;
    bus.disp_is_ls = 0; bus.disp_pred_taken = 0; bus.q1_id = '0; bus.q2_id = '0;
    bus.wb_valid = '0; bus.wb_id = '0; bus.wb_res = '0; bus.wb_taken = '0; bus.wb_target = '0;
    clr_stim();

    scen_inorder(0);

    // fill to DEPTH, over-dispatch, then free one slot and reuse the wrapped tail
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(32'h1000 + 32'(i * 4), 5'(i), 0, 0, 0);
      step();
    end
    set_disp(32'h2000, 5'd31, 0, 0, 0); set_wb(0, 4'd0, 32'h5555, 0, '0);
    drive_check();
    chk("full_at_depth", bus.rob_full, 1);
    chk("tail_wrapped", bus.alloc_id, 0);
    model_step(); clr_stim();
    set_disp(32'h2004, 5'd30, 0, 0, 0); step();
    set_disp(32'h2008, 5'd29, 0, 0, 0);
    drive_check();
    chk("not_full_after_commit", bus.rob_full, 0);
    model_step(); clr_stim();
    drive_check();
    chk("full_again", bus.rob_full, 1);
    chk("alloc_after_wrap", bus.alloc_id, 1);
    model_step(); clr_stim();

    // load at head blocks a ready ALU op from sharing the cycle
    reset_dut();
    set_disp(32'h300, 5'd7, 0, 1, 0); step();
    set_disp(32'h304, 5'd8, 0, 0, 0); step();
    set_wb(0, 4'd0, 32'hAAAA, 0, '0); set_wb(1, 4'd1, 32'hBBBB, 0, '0);
    drive_check();
    chk("ls_commit_head", bus.ls_commit, 1);
    chk("ls_id_head", bus.ls_id, 0);
    model_step(); clr_stim();
    repeat (3) step();

    // mispredicted branch flushes the younger ready entry
    reset_dut();
    set_disp(32'h100, 5'd0, 1, 0, 1); step();
    set_disp(32'h104, 5'd9, 0, 0, 0); step();
    set_wb(0, 4'd0, 32'h0, 0, 32'h500); set_wb(1, 4'd1, 32'h9999, 0, '0); step();
    step();
    set_disp(32'h700, 5'd3, 0, 0, 0); step();
    drive_check();
    chk("flush_cleared_full", bus.rob_full, 0);
    chk("flush_cleared_tail", bus.alloc_id, 0);
    model_step(); clr_stim();
    repeat (2) step();

    // same-cycle writeback bypass on operand lookup
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      set_disp(32'h800 + 32'(i * 4), 5'(i + 10), 0, 0, 0);
      step();
    end
    set_disp(32'h814, 5'd15, 0, 0, 0);
    set_wb(1, 4'd3, 32'h0000_DEAD, 0, '0);
    s_q1 = 4'd3; s_q2 = 4'd4;
    drive_check();
    chk("bypass_q1_ready", bus.q1_ready, 1);
    chk("bypass_q1_val", bus.q1_val, 32'h0000_DEAD);
    chk("bypass_q2_ready", bus.q2_ready, 0);
    model_step(); clr_stim();

    scen_inorder(1);

    for (int i = 0; i < 1500; i++) begin
      rand_cycle(1);
      step();
    end
    for (int i = 0; i < 80; i++) begin
      rand_cycle(0);
      step();
    end
    repeat (4) step();
    @(posedge clk);
    #2;
    chk("exp_queue_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
